// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
//  - IMEM word size, default reset PC, canonical NOP encoding
//  - fetch_entry_t: one buffered instruction {instr, pc}
//  - redirect_target(): branch/JAL/JALR target computation
package instr_fetch_unit_pkg;

  localparam int unsigned IMEM_WORD_BYTES  = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // base + imm with 32-bit wrap; JALR clears bit 0 of the sum.
  function automatic logic [31:0] redirect_target(input logic [31:0] base,
                                                  input logic [31:0] imm,
                                                  input logic        is_jalr);
    logic [31:0] t;
    t = base + imm;
    if (is_jalr) t[0] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buf.sv
// fetch_buf: DEPTH-entry circular FIFO of fetched instructions.
//  clk, rst_n   clock, synchronous active-low reset
//  flush        synchronous clear; wins over push/pop in the same cycle
//  push, push_data  write one entry at the tail
//  pop          retire the head entry (ignored when empty)
//  head         head entry, read combinationally from storage
//  count        current occupancy (0..DEPTH)
module fetch_buf
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] hd_ptr, tl_ptr;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full buffer can still take a push when the head leaves this cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) tl_ptr <= ptr_inc(tl_ptr);
      if (do_pop)  hd_ptr <= ptr_inc(hd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[tl_ptr] <= push_data;
  end

  assign head = mem[hd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues in-order word fetches, buffers up to
// DEPTH words and hands {instr, pc} to decode over valid/ready.
//  clk, rst_n                    clock, synchronous active-low reset
//  imem_req_valid/ready/addr     fetch request channel
//  imem_rsp_valid/data           in-order response, never back-pressured
//  instr_valid/ready, instr, instr_pc   decode channel (buffer head)
//  redir_valid/base/imm/is_jalr  redirect from branch/JAL/JALR
//  fetch_misalign                sticky: redirect target had bit 1 set
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2,
  parameter int          CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_base,
  input  logic [31:0] redir_imm,
  input  logic        redir_is_jalr,
  output logic        fetch_misalign
);

  logic [31:0]      fetch_pc, pc_tail, target;
  logic [CNT_W-1:0] outstanding, outstanding_nxt, drop, occ;
  logic [CNT_W:0]   credit_used;
  logic             live, misalign;
  logic             accept, rsp_keep, pop;
  fetch_entry_t     head;

  // Every buffered word and every in-flight request holds one slot, so a
  // response always has room when it lands.
  assign credit_used = {1'b0, occ} + {1'b0, outstanding};

  // live is low for the first cycle after reset so no valid leaves then.
  assign imem_req_valid = live && !misalign && !redir_valid &&
                          (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop == '0);
  assign pop      = instr_valid && instr_ready && !redir_valid;
  assign target   = redirect_target(redir_base, redir_imm, redir_is_jalr);

  assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      pc_tail     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      misalign    <= 1'b0;
      live        <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redir_valid) begin
        fetch_pc <= target;
        pc_tail  <= target;
        // Everything still in flight after this edge belongs to the old
        // path, including requests already marked for dropping.
        drop     <= outstanding_nxt;
        if (target[1]) misalign <= 1'b1;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + 32'(IMEM_WORD_BYTES);
        if (rsp_keep) pc_tail  <= pc_tail + 32'(IMEM_WORD_BYTES);
        else if (imem_rsp_valid) drop <= drop - CNT_W'(1);
      end
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir_valid),
    .push      (rsp_keep),
    .push_data ('{instr: imem_rsp_data, pc: pc_tail}),
    .pop       (pop),
    .head      (head),
    .count     (occ)
  );

  assign instr_valid    = (occ != '0);
  assign instr          = head.instr;
  assign instr_pc       = head.pc;
  assign fetch_misalign = misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam int          CNT_W = 3;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redir_valid, redir_is_jalr;
  logic [31:0] redir_base, redir_imm;
  logic        fetch_misalign;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redir_valid(redir_valid), .redir_base(redir_base),
    .redir_imm(redir_imm), .redir_is_jalr(redir_is_jalr),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Memory model: accepted requests wait in order until their due cycle.
  typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] rsp_addr;
  int          rsp_ep;
  int          lat_min = 1, lat_max = 1;

  // Reference: the buffer is simply the list of current-path PCs delivered
  // by memory and not yet consumed.
  logic [31:0] bq[$];
  logic [31:0] exp_req;
  logic        exp_mis, exp_live;
  int          epoch = 0;

  logic [31:0] acc_log[$], pop_log[$];
  int          first_acc, first_vld;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        acc, erv;
    logic [31:0] t;
    mreq_t       m;
    @(negedge clk);
    if (!rst_n) begin
      mq.delete(); bq.delete(); epoch++;
      exp_req = RPC; exp_mis = 1'b0; exp_live = 1'b0;
    end else begin
      erv = exp_live && !exp_mis && !redir_valid &&
            ((bq.size() + mq.size() + (imem_rsp_valid ? 1 : 0)) < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(erv));
      if (erv) chk("req_addr", imem_req_addr, exp_req);
      chk("instr_valid", 32'(instr_valid), 32'(bq.size() != 0));
      if (bq.size() != 0) begin
        chk("instr_pc", instr_pc, bq[0]);
        chk("instr", instr, mem_word(bq[0]));
      end
      chk("misalign", 32'(fetch_misalign), 32'(exp_mis));
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
        mq.push_back('{addr: imem_req_addr,
                       due: cyc + int'($urandom_range(lat_max, lat_min)),
                       ep: epoch});
        acc_log.push_back(imem_req_addr);
        if (first_acc < 0) first_acc = cyc;
      end
      if (instr_valid && first_vld < 0) first_vld = cyc;
      if (redir_valid) begin
        t = redir_base + redir_imm;
        if (redir_is_jalr) t[0] = 1'b0;
        bq.delete(); epoch++;
        exp_req = t;
        if (t[1]) exp_mis = 1'b1;
      end else begin
        if (bq.size() != 0 && instr_ready) pop_log.push_back(bq.pop_front());
        if (imem_rsp_valid && rsp_ep == epoch) bq.push_back(rsp_addr);
        if (acc) exp_req = exp_req + 32'd4;
      end
      exp_live = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      rsp_addr       = m.addr;
      rsp_ep         = m.ep;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; redir_valid = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    acc_log.delete(); pop_log.delete();
    first_acc = -1; first_vld = -1;
    #1;
  endtask

  task automatic redirect(input logic [31:0] b, input logic [31:0] i, input logic j);
    redir_valid = 1'b1; redir_base = b; redir_imm = i; redir_is_jalr = j;
    #1;
    chk("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redir_valid = 1'b0;
    acc_log.delete(); pop_log.delete();
  endtask

  typedef struct {
    logic [31:0] base, imm;
    logic        jalr;
    logic [31:0] exp_t;
    logic        exp_mis;
  } rvec_t;

  initial begin
    rvec_t tbl[7];
    logic [31:0] a0, b, im;
    int          n0;

    tbl[0] = '{32'h0000_0100, 32'hFFFF_FFF8, 1'b0, 32'h0000_00F8, 1'b0};
    tbl[1] = '{32'h0000_1000, 32'h0000_0010, 1'b0, 32'h0000_1010, 1'b0};
    tbl[2] = '{32'h0000_0203, 32'h0000_0000, 1'b1, 32'h0000_0202, 1'b1};
    tbl[3] = '{32'h0000_0401, 32'h0000_0003, 1'b1, 32'h0000_0404, 1'b0};
    tbl[4] = '{32'hFFFF_FFF0, 32'h0000_0014, 1'b0, 32'h0000_0004, 1'b0};
    tbl[5] = '{32'h0000_0081, 32'hFFFF_FFFF, 1'b1, 32'h0000_0080, 1'b0};
    tbl[6] = '{32'h0000_0010, 32'h0000_0006, 1'b0, 32'h0000_0016, 1'b1};

    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b1; redir_valid = 1'b0; redir_base = '0; redir_imm = '0;
    redir_is_jalr = 1'b0; rsp_addr = '0; rsp_ep = 0;
    exp_req = RPC; exp_mis = 1'b0; exp_live = 1'b0;

    // Streaming fetch, 1-cycle memory, decode always ready.
    do_reset(2);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
    repeat (12) tick();
    chk("stream_addr0", qget(acc_log, 0), 32'h0);
    chk("stream_addr1", qget(acc_log, 1), 32'h4);
    chk("stream_addr2", qget(acc_log, 2), 32'h8);
    chk("stream_addr3", qget(acc_log, 3), 32'hC);
    chk("fill_latency", 32'(first_vld - first_acc), 32'd2);
    chk("stream_pc0", qget(pop_log, 0), 32'h0);
    chk("stream_pc2", qget(pop_log, 2), 32'h8);

    // Decode stalled: credit limits fetch to DEPTH words.
    do_reset(1);
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("stall_req_count", 32'(acc_log.size()), 32'(DEPTH));
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    chk("stall_head_pc", instr_pc, 32'h0);

    // Memory back-pressure: address held, PC does not advance.
    instr_ready = 1'b1; imem_req_ready = 1'b0;
    repeat (4) tick();
    a0 = imem_req_addr; n0 = acc_log.size();
    chk("bp_addr", a0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_addr", imem_req_addr, a0);
      chk("bp_hold_valid", 32'(imem_req_valid), 32'd1);
    end
    chk("bp_no_accept", 32'(acc_log.size()), 32'(n0));
    imem_req_ready = 1'b1;
    repeat (3) tick();

    // Redirect with two requests in flight; both stale responses dropped.
    lat_min = 3; lat_max = 3;
    do_reset(1);
    repeat (3) tick();
    chk("inflight_before_redir", 32'(acc_log.size()), 32'd2);
    redirect(32'h0000_0100, 32'hFFFF_FFF8, 1'b0);
    repeat (12) tick();
    chk("redir_first_addr", qget(acc_log, 0), 32'h0000_00F8);
    chk("redir_first_pc", qget(pop_log, 0), 32'h0000_00F8);
    chk("redir_second_pc", qget(pop_log, 1), 32'h0000_00FC);

    // Misaligned JALR target halts fetch.
    lat_min = 1; lat_max = 1;
    do_reset(1);
    repeat (3) tick();
    redirect(32'h0000_0203, 32'h0, 1'b1);
    repeat (6) tick();
    chk("mis_flag", 32'(fetch_misalign), 32'd1);
    chk("mis_no_req", 32'(acc_log.size()), 32'd0);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);

    // Address wrap, then reset mid-stream.
    do_reset(1);
    repeat (2) tick();
    redirect(32'hFFFF_FFF0, 32'h0000_000C, 1'b0);
    repeat (8) tick();
    chk("wrap_addr0", qget(acc_log, 0), 32'hFFFF_FFFC);
    chk("wrap_addr1", qget(acc_log, 1), 32'h0);
    chk("wrap_pc0", qget(pop_log, 0), 32'hFFFF_FFFC);
    chk("wrap_pc1", qget(pop_log, 1), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; acc_log.delete(); #1;
    chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (4) tick();
    chk("midrst_first_addr", qget(acc_log, 0), RPC);

    // Redirect target table.
    for (int r = 0; r < 7; r++) begin
      do_reset(1);
      repeat (4) tick();
      redirect(tbl[r].base, tbl[r].imm, tbl[r].jalr);
      for (int w = 0; w < 8 && acc_log.size() == 0; w++) tick();
      chk("tbl_misalign", 32'(fetch_misalign), 32'(tbl[r].exp_mis));
      if (tbl[r].exp_mis) chk("tbl_no_req", 32'(acc_log.size()), 32'd0);
      else                chk("tbl_target", qget(acc_log, 0), tbl[r].exp_t);
    end

    // Randomized traffic against the reference model.
    lat_min = 1; lat_max = 4;
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      instr_ready    = ($urandom_range(9, 0) < 7);
      rst_n          = ($urandom_range(199, 0) != 0);
      redir_valid    = ($urandom_range(24, 0) == 0);
      if (redir_valid) begin
        redir_is_jalr = $urandom_range(1, 0) != 0;
        b  = $urandom;
        b[1:0] = redir_is_jalr ? 2'b01 : 2'b00;
        im = 32'($urandom_range(255, 0)) << 2;
        if ($urandom_range(1, 0) != 0) im = -im;
        if ($urandom_range(9, 0) == 0) im = im + 32'd2;
        redir_base = b; redir_imm = im;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
